// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage (LO=quotient, HI=remainder).
// Optional early exit for |divisor| > |dividend| is compiled in with DIV_EARLY_EXIT_EN.
`timescale 1ns/1ps
module ex_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] opdata1,
  input  logic [DATA_W-1:0] opdata2,
  input  logic              cancel,
  output logic              stall_req,
  output logic              result_valid,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              hi_we,
  output logic              lo_we
);

  localparam int CNT_W  = $clog2(DATA_W) + 1;
  localparam int WORK_W = 2 * DATA_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ON      = 3'd1,
    S_DIVZERO = 3'd2,
    S_END     = 3'd3
`ifdef DIV_EARLY_EXIT_EN
    , S_FAST  = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic [DATA_W-1:0]   dividend_q, dividend_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0]   quotient_q, quotient_d;
  logic [DATA_W-1:0]   remainder_q, remainder_d;
  logic                result_valid_q, result_valid_d;

  logic                sign1, sign2;
  logic [DATA_W-1:0]   mag1, mag2;
  logic [WORK_W-1:0]   shifted;
  logic [DATA_W:0]     diff;
  logic [WORK_W-1:0]   step_work;
  logic [DATA_W-1:0]   step_quo, step_rem;

  always_comb begin
    sign1 = signed_div & opdata1[DATA_W-1];
    sign2 = signed_div & opdata2[DATA_W-1];
    mag1  = sign1 ? -opdata1 : opdata1;
    mag2  = sign2 ? -opdata2 : opdata2;
  end

  // One restoring step: shift, trial-subtract, keep the difference only if it did not go negative.
  always_comb begin
    shifted   = work_q << 1;
    diff      = shifted[WORK_W-1:DATA_W] - {1'b0, divisor_q};
    step_work = diff[DATA_W] ? shifted : {diff, shifted[DATA_W-1:1], 1'b1};
    step_quo  = step_work[DATA_W-1:0];
    step_rem  = step_work[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    divisor_d   = divisor_q;
    dividend_d  = dividend_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          dividend_d = opdata1;
          divisor_d  = mag2;
          work_d     = {{(DATA_W+1){1'b0}}, mag1};
          neg_quo_d  = sign1 ^ sign2;
          neg_rem_d  = sign1;
          if (opdata2 == '0) begin
            state_d = S_DIVZERO;
`ifdef DIV_EARLY_EXIT_EN
          end else if (mag2 > mag1) begin
            state_d = S_FAST;
`endif
          end else begin
            state_d = S_ON;
          end
        end
      end
      S_DIVZERO: begin
        quotient_d  = '1;
        remainder_d = dividend_q;
        state_d     = S_END;
      end
`ifdef DIV_EARLY_EXIT_EN
      S_FAST: begin
        quotient_d  = '0;
        remainder_d = dividend_q;
        state_d     = S_END;
      end
`endif
      S_ON: begin
        work_d = step_work;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          quotient_d  = neg_quo_q ? -step_quo : step_quo;
          remainder_d = neg_rem_q ? -step_rem : step_rem;
          cnt_d       = '0;
          state_d     = S_END;
        end
      end
      S_END: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flush wins over everything, including a divide completing this cycle.
    if (cancel) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    result_valid_d = (state_d == S_END);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      work_q         <= '0;
      divisor_q      <= '0;
      dividend_q     <= '0;
      neg_quo_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
      quotient_q     <= '0;
      remainder_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      work_q         <= work_d;
      divisor_q      <= divisor_d;
      dividend_q     <= dividend_d;
      neg_quo_q      <= neg_quo_d;
      neg_rem_q      <= neg_rem_d;
      quotient_q     <= quotient_d;
      remainder_q    <= remainder_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign stall_req    = start & ~result_valid_q & ~cancel;
  assign result_valid = result_valid_q;
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign hi_we        = result_valid_q;
  assign lo_we        = result_valid_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: driver pushes reference results, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        cancel = 1'b0;
  logic        stall_req, result_valid, hi_we, lo_we;
  logic [31:0] quotient, remainder;

  ex_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .opdata1(opdata1), .opdata2(opdata2), .cancel(cancel),
    .stall_req(stall_req), .result_valid(result_valid),
    .quotient(quotient), .remainder(remainder),
    .hi_we(hi_we), .lo_we(lo_we)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division as MIPS does.
  function automatic void ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
    longint sa, sbv, ma, mb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 2;
    end else begin
      sa  = sg ? longint'($signed(a)) : longint'(a);
      sbv = sg ? longint'($signed(b)) : longint'(b);
      q   = 32'(sa / sbv);
      r   = 32'(sa % sbv);
      ma  = (sa < 0) ? -sa : sa;
      mb  = (sbv < 0) ? -sbv : sbv;
      lat = 33;
`ifdef DIV_EARLY_EXIT_EN
      if (mb > ma) lat = 2;
`else
      if (mb > ma) lat = 33;
`endif
    end
  endfunction

  // Monitor: pops one expectation per rising result_valid, then checks the result stays put.
  logic        rv_prev = 1'b0;
  logic [31:0] last_q = '0, last_r = '0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result actual=q%h/r%h required=no result", quotient, remainder);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
        check("hi_we", {31'b0, hi_we}, 32'd1);
        check("lo_we", {31'b0, lo_we}, 32'd1);
        $display("result q=%h r=%h lat=%0d", quotient, remainder, cyc - mon_e.t0);
        last_q <= mon_e.q;
        last_r <= mon_e.r;
      end
    end else if (result_valid && rv_prev) begin
      check("hold_quotient", quotient, last_q);
      check("hold_remainder", remainder, last_r);
    end
    rv_prev <= result_valid;
  end

  task automatic run_div(input bit sg, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    int   n;
    ref_div(sg, a, b, e.q, e.r, e.lat);
    @(negedge clk);
    start = 1'b1; signed_div = sg; opdata1 = a; opdata2 = b;
    #1;
    check("stall_at_issue", {31'b0, stall_req}, 32'd1);
    e.t0 = cyc;
    sb.push_back(e);
    $display("issue %s a=%h b=%h expect q=%h r=%h lat=%0d", sg ? "DIV " : "DIVU", a, b, e.q, e.r, e.lat);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      // Operands are only sampled in IDLE, so scrambling them now must not matter.
      opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
    end while (!result_valid && n < 60);
    if (!result_valid) begin
      checks++; errors++;
      $display("FAIL timeout actual=no result_valid required=result within 60 cycles");
      void'(sb.pop_back());
      start = 1'b0;
      return;
    end
    #1;
    check("stall_at_result", {31'b0, stall_req}, 32'd0);
    repeat (hold) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    check("rv_cleared", {31'b0, result_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    bit          sg;
    int          n;

    repeat (3) @(negedge clk);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_rv", {31'b0, result_valid}, 32'd0);
    check("reset_stall", {31'b0, stall_req}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_div(1'b0, 32'd100, 32'd7, 1);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2);
    run_div(1'b0, 32'd5, 32'd0, 1);
    run_div(1'b0, 32'd3, 32'd10, 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd10, 0);

    // Cancel mid-operation: nothing is expected from this divide.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'hFFFF_FFFF; opdata2 = 32'd3;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    #1;
    check("stall_during_cancel", {31'b0, stall_req}, 32'd0);
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    #1;
    check("rv_after_cancel", {31'b0, result_valid}, 32'd0);
    check("stall_after_cancel", {31'b0, stall_req}, 32'd0);
    $display("cancel done");
    run_div(1'b0, 32'd9, 32'd3, 0);

    // Asynchronous reset in the middle of ON.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_quotient", quotient, 32'd0);
    check("async_rst_remainder", remainder, 32'd0);
    check("async_rst_rv", {31'b0, result_valid}, 32'd0);
    start = 1'b0;
    #1;
    check("async_rst_stall", {31'b0, stall_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_rv", {31'b0, result_valid}, 32'd0);
    check("post_rst_stall", {31'b0, stall_req}, 32'd0);
    $display("async reset done");

    for (int i = 0; i < 25; i++) begin
      sg = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
        2: begin a = $urandom; b = 32'd0; end
        default: begin a = $urandom_range(0, 50); b = $urandom_range(51, 5000); end
      endcase
      if ($urandom_range(0, 3) == 0) a = -a;
      run_div(sg, a, b, $urandom_range(0, 2));
    end

    // start dropping mid-ON: the divide still completes and the unit goes straight back to IDLE.
    begin
      exp_t e;
      ref_div(1'b0, 32'd50, 32'd5, e.q, e.r, e.lat);
      @(negedge clk);
      start = 1'b1; signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5;
      e.t0 = cyc;
      sb.push_back(e);
      repeat (5) @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!result_valid && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (!result_valid) begin
        checks++; errors++;
        $display("FAIL drop_timeout actual=no result_valid required=result within 60 cycles");
        void'(sb.pop_back());
      end
      @(negedge clk);
      check("drop_rv_cleared", {31'b0, result_valid}, 32'd0);
      $display("start-drop done");
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative 32-bit radix-2 restoring divider instantiated inside the EX stage.
- Executes MIPS DIV/DIVU and produces HI (remainder) and LO (quotient).
- Its outputs feed the hi_ex_we/hi_ex_wdata/lo_ex_we/lo_ex_wdata fields of the EX-to-MEM bus.
- Holds the pipeline via a stall request until the result is ready.

Parameters:
- DATA_W, 32, operand/result width. Only 32 is supported; the counter is log2(DATA_W)+1 bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  EX has a DIV/DIVU in flight; held high while EX is stalled on this op
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start in IDLE
- opdata1  in  32  dividend (rs); sampled with start in IDLE
- opdata2  in  32  divisor (rt); sampled with start in IDLE
- cancel  in  1  flush; aborts any operation
- stall_req  out  1  to stall controller; freezes IF/ID/EX while the divide is pending
- result_valid  out  1  quotient/remainder valid this cycle
- quotient  out  32  LO write data
- remainder  out  32  HI write data
- hi_we  out  1  = result_valid
- lo_we  out  1  = result_valid

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, all datapath regs 0, result_valid=0, quotient=0, remainder=0. stall_req=0 because it is combinational from state and start.
- States and transitions:
  - IDLE: start=1 & cancel=0 & opdata2==0 -> DIVZERO. start=1 & cancel=0 -> ON. Otherwise stay.
  - DIVZERO: next cycle -> END with quotient=32'hFFFFFFFF, remainder=dividend (raw opdata1).
  - ON: 32 iterations, one per cycle, counter 0..31. After the iteration with counter==31 -> END.
  - END: result_valid=1. Stay while start=1. start=0 -> IDLE and clear result_valid.
  - Any state with cancel=1: -> IDLE next edge, clear result_valid, reset counter. Cancel has priority over every transition, including completion in the same cycle.
- Signed handling, latched at start:
  - Operate on magnitudes; record neg_q = sign1 ^ sign2 and neg_r = sign1.
  - In the final ON cycle, negate quotient if neg_q and remainder if neg_r.
  - 0x80000000 / 0xFFFFFFFF (signed): quotient=0x80000000 (wraps), remainder=0.
- Iteration step:
  - 65-bit work register {rem[32:0], quo[31:0]}, shifted left by 1.
  - Trial subtract of 33-bit {0,divisor}. Non-negative: keep the difference and set quotient LSB=1; else restore and set 0.
- Latency:
  - Nonzero divisor: start seen in IDLE at cycle T -> result_valid at T+33.
  - Zero divisor: result_valid at T+2.
  - result_valid holds until start drops.
- stall_req = start & ~result_valid & ~cancel. EX releases on the cycle result_valid=1, so the EX-to-MEM register captures hi_we/lo_we and the data exactly once.
- quotient and remainder are registered and stable throughout END. Their values in other states are don't-care but must not change in ON until the final cycle.
- Operand changes during ON/END are ignored; operands are sampled only in IDLE.
- start dropping mid-ON without cancel: finish the operation and return to IDLE directly from END next cycle (result discarded).
- Back-to-back divides: start must drop for at least 1 cycle (END->IDLE) before the next op is accepted.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in IDLE, if the divisor magnitude is greater than the dividend magnitude (unsigned compare after abs) and the divisor is nonzero, go to a FAST state. FAST -> END next cycle with quotient=0 and remainder=opdata1 (original signed value). Latency is T+2.
- Undefined: no FAST state; all nonzero-divisor ops take the full 33 cycles.

Test Plan:
- DIVU 100/7: start at T -> stall_req=1 for T..T+32; at T+33 result_valid=1, quotient=14, remainder=2, hi_we=lo_we=1; start drops -> IDLE next cycle.
- DIV -7/2: quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0.
- DIVU 5/0: result_valid at T+2, quotient=0xFFFFFFFF, remainder=5; no ON cycles.
- cancel=1 at T+10 of DIVU 0xFFFFFFFF/3: next cycle state=IDLE, result_valid=0, stall_req=0. A new DIVU 9/3 started 1 cycle later gives quotient=3, remainder=0.
- rst pulled low at T+20 mid-ON: outputs zero immediately (async). After release, IDLE with stall_req=0 and start=0.
- DIVU 3/10: with DIV_EARLY_EXIT_EN, result at T+2 with quotient=0, remainder=3. Without it, same values at T+33.
